// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO.
// Baud timing comes from an external one-cycle tick; frame is start, LSB-first data, optional parity, stop bits.
module uart_tx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int DEPTH       = 4
) (
    input  logic                   system_clock,
    input  logic                   rst,
    input  logic                   clock_enable,
    input  logic [DATA_BITS-1:0]   data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   tx_busy,
    output logic                   Tx
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   push, pop;
    logic [DATA_BITS-1:0]   head;

    assign head       = mem_q[rd_ptr_q];
    assign data_ready = (count_q < DEPTH_C);
    assign push       = data_valid && data_ready;
    assign fifo_count = count_q;
    assign tx_busy    = (state_q != IDLE);
    assign Tx         = tx_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        if (clock_enable) begin
            unique case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    pop  = (count_q != '0);
                end
                START: begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
                DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_MODE != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                PARITY: begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                STOP: begin
                    if (stop_cnt_q == STOP_LAST) begin
                        pop = (count_q != '0);
                        if (!pop) begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Loading a word is shared by IDLE and back-to-back STOP; parity is fixed at load time.
            if (pop) begin
                state_d  = START;
                tx_d     = 1'b0;
                shift_d  = head;
                parity_d = (^head) ^ ODD;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_q + PW'(push);
            rd_ptr_q   <= rd_ptr_q + PW'(pop);
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
        end
    end

    always_ff @(posedge system_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have parameter DEPTH, default 4, meaning transmit FIFO entries; power of two, minimum 2.
REQ-005 SHALL have port system_clock  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port clock_enable  input  1  one-cycle baud tick; one bit period per tick.
REQ-008 SHALL have port data_in  input  DATA_BITS  word to transmit.
REQ-009 SHALL have port data_valid  input  1  data_in offered this cycle.
REQ-010 SHALL have port data_ready  output  1  FIFO can accept a word this cycle.
REQ-011 SHALL have port fifo_count  output  $clog2(DEPTH)+1  words currently queued.
REQ-012 SHALL have port tx_busy  output  1  frame in progress (any state but IDLE).
REQ-013 SHALL have port Tx  output  1  serial line; idle high.

Function
REQ-014 SHALL accept a word on any system_clock edge where data_valid && data_ready, independent of clock_enable.
REQ-015 SHALL drive data_ready = (fifo_count < DEPTH), combinationally from the count; valid while full is ignored, with no overwrite.
REQ-016 SHALL implement the FIFO with wrapping read/write pointers; order is first-in first-out.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, advancing only on edges with clock_enable=1.
REQ-018 SHALL register Tx: on an enabled edge, state and Tx update together, and Tx takes the bit of the newly entered state.
REQ-019 IDLE: on a tick with fifo_count>0, SHALL pop one word into the shift register, enter START, and drive Tx=0; otherwise Tx=1.
REQ-020 START: after one tick, SHALL enter DATA with Tx=bit0 (LSB first) and bit counter=0.
REQ-021 DATA: SHALL shift once per tick, for DATA_BITS ticks total, then go to PARITY if PARITY_MODE!=0, else to STOP.
REQ-022 PARITY: SHALL send for one tick the XOR of all payload bits (even) or its inverse (odd).
REQ-023 STOP: SHALL hold Tx=1 for STOP_BITS ticks.
REQ-024 At the end of STOP, SHALL go directly to START (popping the next word, no idle bit) if fifo_count>0, else go to IDLE.
REQ-025 Frame length SHALL be 1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS ticks.
REQ-026 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a pop SHALL never occur when empty.
REQ-027 A change of data_in after acceptance SHALL NOT affect a queued or in-flight frame.

Reset
REQ-028 On a system_clock edge with rst=1, SHALL set: state IDLE, Tx=1, tx_busy=0, fifo_count=0, pointers 0, bit counter 0, data_ready=1.
REQ-029 Reset mid-frame SHALL abort the frame and flush the FIFO; Tx=1 from the next edge.
REQ-030 Reset SHALL take priority over clock_enable and data_valid.

Verification
REQ-031 Default parameters; push 0xA5; ticks every 16 clocks -> Tx = 0,1,0,1,0,0,1,0,1,1 per tick; tx_busy high for exactly 10 ticks.
REQ-032 PARITY_MODE=1, STOP_BITS=2; push 0x07 -> parity bit 1 and two stop bits; PARITY_MODE=2 -> parity bit 0; frame is 12 ticks.
REQ-033 DEPTH=4, no ticks; push 5 words -> data_ready low after the 4th push, 5th word dropped, fifo_count=4.
REQ-034 Queue 0x11 and 0x22 -> second start bit on the tick immediately after the first stop bit; tx_busy never drops between frames.
REQ-035 Assert rst during DATA bit 3 -> next edge Tx=1, tx_busy=0, fifo_count=0; a later push transmits a clean frame.
REQ-036 Push while FIFO at DEPTH-1 in the same cycle as an IDLE pop tick -> fifo_count unchanged, all words sent in order.
